// File: rtl/mux_lut_pkg.sv
// ============================================================================
// Module  : mux_lut_pkg
// Brief   : Shared types and defaults for the mux_lut_cell programmable LUT.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_lut_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_t;

    localparam int         DEFAULT_K    = 2;
    localparam logic [3:0] DEFAULT_INIT = 4'b1000;

endpackage

`default_nettype wire

// File: rtl/mux_lut_cell_mux_tree.sv
// ============================================================================
// Module  : mux_tree
// Brief   : Combinational K-level tree of 2:1 muxes; sel_i bit 0 drives the
//           leaf level, so data_i[sel_i] appears on out_o.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_tree #(
    parameter int K = 2
) (
    input  logic [(2**K)-1:0] data_i,
    input  logic [K-1:0]      sel_i,
    output logic              out_o
);

    localparam int N = 2**K;

    // Nodes stored level by level: level l occupies [2N - 2N/2^l, +N/2^l).
    logic [2*N-2:0] node;

    generate
        for (genvar i = 0; i < N; i++) begin : g_leaf
            assign node[i] = data_i[i];
        end

        for (genvar l = 1; l <= K; l++) begin : g_lvl
            localparam int OFF_IN  = 2*N - ((2*N) >> (l-1));
            localparam int OFF_OUT = 2*N - ((2*N) >> l);
            for (genvar j = 0; j < (N >> l); j++) begin : g_node
                assign node[OFF_OUT+j] = sel_i[l-1] ? node[OFF_IN+2*j+1]
                                                    : node[OFF_IN+2*j];
            end
        end
    endgenerate

    assign out_o = node[2*N-2];

endmodule

`default_nettype wire

// File: rtl/mux_lut_cell.sv
// ============================================================================
// Module  : mux_lut_cell
// Brief   : K-input LUT with registered output and serial, run-time
//           reprogrammable truth table. Optional MUX_LUT_READBACK_EN macro
//           adds a table_out port showing the active table.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_lut_cell
    import mux_lut_pkg::*;
#(
    parameter int               K    = DEFAULT_K,
    parameter logic [(2**K)-1:0] INIT = DEFAULT_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_bit,
    input  logic              in_valid,
    input  logic [K-1:0]      in_data,
    output logic              out_valid,
`ifdef MUX_LUT_READBACK_EN
    output logic              out_data,
    output logic [(2**K)-1:0] table_out
`else
    output logic              out_data
`endif
);

    localparam int         N        = 2**K;
    localparam logic [K:0] CNT_LAST = (K+1)'(N-1);

    lut_state_t     state_q, state_d;
    logic [N-1:0]   shadow_q, shadow_d;
    logic [N-1:0]   table_q, table_d;
    logic [K:0]     cnt_q, cnt_d;
    logic           out_valid_q, out_data_q;
    logic           cfg_accept;
    logic           lut_out;

    assign cfg_accept = cfg_valid & cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (cfg_accept) state_d = LOAD;
            LOAD:    if (cfg_accept && cnt_q == CNT_LAST) state_d = COMMIT;
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        if (!rst && state_q != COMMIT) cfg_ready = 1'b1;
    end

    always_comb begin
        shadow_d = shadow_q;
        table_d  = table_q;
        cnt_d    = cnt_q;
        case (state_q)
            RUN: if (cfg_accept) begin
                shadow_d = {shadow_q[N-2:0], cfg_bit};
                cnt_d    = (K+1)'(1);
            end
            LOAD: if (cfg_accept) begin
                shadow_d = {shadow_q[N-2:0], cfg_bit};
                cnt_d    = cnt_q + (K+1)'(1);
            end
            COMMIT: begin
                table_d = shadow_q;
                cnt_d   = '0;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            table_q  <= INIT;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            table_q  <= table_d;
            cnt_q    <= cnt_d;
        end
    end

    mux_tree #(
        .K (K)
    ) u_mux_tree (
        .data_i (table_q),
        .sel_i  (in_data),
        .out_o  (lut_out)
    );

    // Output holds its last value between requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) out_data_q <= lut_out;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef MUX_LUT_READBACK_EN
    assign table_out = table_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_lut_cell.sv
// ============================================================================
// Module  : tb_mux_lut_cell
// Brief   : Scoreboard bench for mux_lut_cell (K=2, INIT=AND).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_lut_cell;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_bit;
    logic       in_valid;
    logic [1:0] in_data;
    logic       out_valid;
    logic       out_data;
`ifdef MUX_LUT_READBACK_EN
    logic [3:0] table_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit exp_q[$];

    mux_lut_cell #(
        .K    (2),
        .INIT (4'b1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bit   (cfg_bit),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
`ifdef MUX_LUT_READBACK_EN
        .out_data  (out_data),
        .table_out (table_out)
`else
        .out_data  (out_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic lookup(input logic [1:0] d, input bit exp);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Monitor: every presented result consumes one expected value.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no result");
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_errors++;
                    $display("FAIL lookup_result: got %b expected %b", out_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 2'b00;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef MUX_LUT_READBACK_EN
        check("rst_table_out", 32'(table_out), 32'h8);
`endif
        tick();

        // AND table after reset
        lookup(2'b00, 1'b0);
        lookup(2'b01, 1'b0);
        lookup(2'b10, 1'b0);
        lookup(2'b11, 1'b1);

        // XOR back-to-back: 0,1,1,0 MSB first
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("commit_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        check("after_commit_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef MUX_LUT_READBACK_EN
        check("xor_table_out", 32'(table_out), 32'h6);
`endif
        lookup(2'b01, 1'b1);
        lookup(2'b11, 1'b0);
        lookup(2'b00, 1'b0);
        lookup(2'b10, 1'b1);

        // AND load with cfg_valid held through COMMIT; the held bit starts a new load
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b0;
        tick();
        cfg_bit = 1'b1;
        check("held_commit_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        check("held_after_commit_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("held_load_commit_ready", 32'(cfg_ready), 32'd0);
        tick();
        lookup(2'b11, 1'b1);
        lookup(2'b01, 1'b0);
        lookup(2'b10, 1'b0);
        lookup(2'b00, 1'b0);

        // XOR with gaps; lookups mid-load still see AND; lookup in COMMIT is old table
        send_bit(1'b0);
        lookup(2'b11, 1'b1);
        send_bit(1'b1);
        tick();
        lookup(2'b10, 1'b0);
        send_bit(1'b1);
        tick();
        tick();
        lookup(2'b11, 1'b1);
        send_bit(1'b0);
        check("gap_commit_cfg_ready", 32'(cfg_ready), 32'd0);
        lookup(2'b11, 1'b1);
        lookup(2'b11, 1'b0);
        lookup(2'b01, 1'b1);

        // Reset mid-load after two bits
        send_bit(1'b1);
        send_bit(1'b0);
        in_valid = 1'b1;
        in_data  = 2'b11;
        tick();
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midload_rst_out_valid", 32'(out_valid), 32'd0);
        check("midload_rst_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midload_release_ready", 32'(cfg_ready), 32'd1);
        tick();
        lookup(2'b11, 1'b1);
        lookup(2'b01, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("three_bits_no_commit", 32'(cfg_ready), 32'd1);
        lookup(2'b11, 1'b1);
        send_bit(1'b0);
        check("fourth_bit_commit", 32'(cfg_ready), 32'd0);
        tick();
        lookup(2'b11, 1'b0);
        lookup(2'b01, 1'b1);

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
